fp_normalize_shifter: RTL
=========================

Name: fp_normalize_shifter

Overview:
- Sequential normalizer that consumes the leading-one index produced by the first-1 detector and performs the matching normalization shift on a 25-bit mantissa, adjusting the exponent to match.
- Sits after the adder/subtractor mantissa datapath and the leading-one detector, before rounding and packing.
- Uses a 5-stage logarithmic shifter, iterated one stage per clock. A valid/ready handshake is used on both sides.

Parameters:
- MANT_W, 25, mantissa width including the overflow bit (bit 24) and the hidden bit (bit 23).
- POS_W, 5, width of the leading-one index.
- EXP_W, 8, biased exponent width.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  block can accept an operand.
- in_mant  input  MANT_W  unnormalized mantissa.
- in_pos  input  POS_W  bit index of the leading one in in_mant (0..24).
- in_exp  input  EXP_W  biased exponent before normalization.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_mant  output  MANT_W  normalized mantissa; leading one at bit 23, bit 24 = 0.
- out_exp  output  EXP_W  adjusted exponent.
- out_sticky  output  1  OR of bits shifted out on a right shift.
- out_zero  output  1  in_mant was zero.
- out_uflow  output  1  exponent underflow; result flushed to zero.
- out_oflow  output  1  exponent overflow; result is infinity.
- out_err  output  1  in_pos > 24; operand passed through unchanged.

Behaviour:
- FSM states: IDLE, SHIFT, DONE.
- Reset (async, rst_n=0): state=IDLE, stage counter=0. All out_* registers are 0; out_valid=0.
- in_ready = (state==IDLE). Accept on the edge where in_valid & in_ready.
- Accept edge (IDLE->SHIFT):
  - Latch mant, exp, pos; clear flags.
  - If pos==24: mant = mant>>1, sticky = mant[0], exp = exp+1, left-shift amount L=0.
  - Else: L = 23-pos (5 bits).
  - Stage counter = 4.
- SHIFT, one cycle per stage k = 4,3,2,1,0: if L[k], mant <<= 2^k and exp -= 2^k. Counter decrements each cycle.
- Leaving SHIFT: after the k=0 edge, go to DONE with out_valid=1.
- Latency: out_valid rises 5 cycles after the accept edge, and is constant for every case, including zero/err/flag cases.
- Flag priority: evaluated at the accept edge, applied on entry to DONE. Priority is err > zero > oflow > uflow.
  - err (pos>24): out_mant=in_mant, out_exp=in_exp, other flags 0.
  - zero (in_mant==0): out_mant=0, out_exp=0.
  - oflow (pos==24 and in_exp==2^EXP_W-2): out_exp=all ones, out_mant=0, sticky=0.
  - uflow (L>0 and in_exp<=L): out_mant=0, out_exp=0, sticky=0.
- Exponent arithmetic uses EXP_W+1 bits internally. Pre-checked flags guarantee no wrap is ever visible.
- DONE:
  - Outputs hold stable while out_ready=0.
  - On out_valid & out_ready: go to IDLE, out_valid=0 on the next cycle. Data outputs keep their last value.
  - No same-cycle accept in DONE; maximum throughput is 1 operand per 7 cycles.
- in_* values are ignored outside the accept edge; changing them mid-SHIFT has no effect.
- Reset asserted mid-SHIFT or in DONE aborts the operation immediately. No output is produced for the aborted operand.

Test Plan:
- Left-shift path: in_mant=0x0000001, in_pos=0, in_exp=100 -> 5 cycles later out_mant=0x0800000, out_exp=77, all flags 0.
- Right-shift path: in_mant=0x1800001, in_pos=24, in_exp=10 -> out_mant=0x0C00000, out_exp=11, out_sticky=1.
- Already normalized: in_mant=0x0A00000, in_pos=23, in_exp=50 -> out_mant=0x0A00000, out_exp=50, latency still 5 cycles.
- Boundaries:
  - in_mant=0x0000100, pos=8, exp=10 -> out_uflow=1, mant=0, exp=0.
  - in_pos=24, exp=254 -> out_oflow=1, exp=255, mant=0.
  - in_mant=0 -> out_zero=1.
  - in_pos=30 -> out_err=1 with the input passed through.
- Handshake: hold out_ready=0 for 3 cycles in DONE -> outputs stable and in_ready=0 throughout. Raise out_ready -> in_ready=1 the next cycle. A back-to-back second operand is accepted only then.
- Reset mid-operation: assert rst_n=0 at the 3rd SHIFT cycle -> out_valid=0 and in_ready=1 after release. A fresh operand then completes with correct values.

Source files
------------

// File: rtl/fp_normalize_shifter.sv
// Normalization shifter: uses the leading-one index to shift the mantissa so its
// leading one lands at bit 23, adjusting the exponent. One log-shifter stage per clock.
module fp_normalize_shifter #(
  parameter int MANT_W = 25,
  parameter int POS_W  = 5,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_mant,
  input  logic [POS_W-1:0]  in_pos,
  input  logic [EXP_W-1:0]  in_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MANT_W-1:0] out_mant,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_sticky,
  output logic              out_zero,
  output logic              out_uflow,
  output logic              out_oflow,
  output logic              out_err
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]        state;
  logic [2:0]        cnt;
  logic [MANT_W-1:0] mant;
  logic [EXP_W:0]    exp;
  logic [POS_W-1:0]  lsh;
  logic              sticky, f_err, f_zero, f_oflow, f_uflow;

  logic              pos_top, pos_err, acc_uflow, acc_oflow;
  logic [POS_W-1:0]  lsh_acc;
  logic [MANT_W-1:0] mant_nx;
  logic [EXP_W:0]    exp_nx;

  assign in_ready = (state == IDLE);

  // Flags are decided once from the raw operand; the shift then runs uniformly
  // so latency never depends on the operand.
  always_comb begin
    pos_top   = (in_pos == POS_W'(MANT_W-1));
    pos_err   = (in_pos > POS_W'(MANT_W-1));
    lsh_acc   = (pos_top || pos_err) ? '0 : (POS_W'(MANT_W-2) - in_pos);
    acc_uflow = (lsh_acc != '0) && ({1'b0, in_exp} <= (EXP_W+1)'(lsh_acc));
    acc_oflow = pos_top && (in_exp == {{(EXP_W-1){1'b1}}, 1'b0});
  end

  always_comb begin
    mant_nx = mant;
    exp_nx  = exp;
    if (lsh[cnt]) begin
      mant_nx = mant << ((POS_W)'(1) << cnt);
      exp_nx  = exp - ((EXP_W+1)'(1) << cnt);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      mant       <= '0;
      exp        <= '0;
      lsh        <= '0;
      sticky     <= 1'b0;
      f_err      <= 1'b0;
      f_zero     <= 1'b0;
      f_oflow    <= 1'b0;
      f_uflow    <= 1'b0;
      out_valid  <= 1'b0;
      out_mant   <= '0;
      out_exp    <= '0;
      out_sticky <= 1'b0;
      out_zero   <= 1'b0;
      out_uflow  <= 1'b0;
      out_oflow  <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          state   <= SHIFT;
          cnt     <= 3'd4;
          lsh     <= lsh_acc;
          f_err   <= pos_err;
          f_zero  <= (in_mant == '0);
          f_oflow <= acc_oflow;
          f_uflow <= acc_uflow;
          if (pos_top) begin
            mant   <= in_mant >> 1;
            sticky <= in_mant[0];
            exp    <= {1'b0, in_exp} + (EXP_W+1)'(1);
          end else begin
            mant   <= in_mant;
            sticky <= 1'b0;
            exp    <= {1'b0, in_exp};
          end
        end
        SHIFT: begin
          mant <= mant_nx;
          exp  <= exp_nx;
          cnt  <= cnt - 3'd1;
          if (cnt == 3'd0) begin
            state      <= DONE;
            out_valid  <= 1'b1;
            out_mant   <= mant_nx;
            out_exp    <= exp_nx[EXP_W-1:0];
            out_sticky <= sticky;
            out_err    <= f_err;
            out_zero   <= 1'b0;
            out_oflow  <= 1'b0;
            out_uflow  <= 1'b0;
            if (f_err) begin
              out_sticky <= 1'b0;
            end else if (f_zero) begin
              out_zero   <= 1'b1;
              out_mant   <= '0;
              out_exp    <= '0;
              out_sticky <= 1'b0;
            end else if (f_oflow) begin
              out_oflow  <= 1'b1;
              out_mant   <= '0;
              out_exp    <= '1;
              out_sticky <= 1'b0;
            end else if (f_uflow) begin
              out_uflow  <= 1'b1;
              out_mant   <= '0;
              out_exp    <= '0;
              out_sticky <= 1'b0;
            end
          end
        end
        DONE: if (out_ready) begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
